// File: rtl/poly_decim_fir.sv
// Decimate-by-D FIR filter built around one time-shared multiply-accumulate unit,
// with round-half-up output scaling, saturation and a sticky overflow flag.
module poly_decim_fir #(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned COEF_W    = 10,
    parameter int unsigned NTAPS     = 21,
    parameter int unsigned D         = 2,
    // tap 0 sits in the least-significant slot, so this literal lists tap NTAPS-1 down to tap 0
    parameter logic [NTAPS*COEF_W-1:0] COEFS = {
        10'h3FF, 10'h004, 10'h009, 10'h005, 10'h3F1, 10'h3DC, 10'h3EA,
        10'h033, 10'h0A1, 10'h0F4, 10'h0F4, 10'h0A1, 10'h033, 10'h3EA,
        10'h3DC, 10'h3F1, 10'h005, 10'h009, 10'h004, 10'h3FF, 10'h3FC},
    parameter int unsigned OUT_W     = 20,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [IN_W-1:0]  x,
    output logic             y_valid,
    output logic [OUT_W-1:0] y,
    output logic             ovf
);
    localparam int unsigned T_W    = $clog2(NTAPS);
    localparam int unsigned P_W    = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned PROD_W = IN_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(NTAPS);
    localparam int unsigned R_W    = ACC_W + 1;
    localparam int unsigned RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic [R_W-1:0] RND    = (OUT_SHIFT > 0) ? (R_W'(1) << RND_SH) : '0;
    localparam logic [T_W-1:0] T_LAST = T_W'(NTAPS - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(D - 1);

    typedef enum logic {IDLE, MAC} state_t;

    state_t                   state, state_next;
    logic signed [COEF_W-1:0] coef [NTAPS];
    logic signed [IN_W-1:0]   dl   [NTAPS];
    logic [T_W-1:0]           t;
    logic [P_W-1:0]           p;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic signed [PROD_W-1:0] prod;
    logic signed [R_W-1:0]    sum_r, r;
    logic [OUT_W-1:0]         y_next;
    logic                     fits, accept, start, load;

    for (genvar k = 0; k < NTAPS; k++) begin : g_coef
        assign coef[k] = COEFS[k*COEF_W +: COEF_W];
    end

    assign accept = x_valid && x_ready && !flush;

    // Next-state: a completed group of D samples launches one NTAPS-cycle MAC pass
    always_comb begin
        state_next = state;
        start      = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: if (accept && p == P_LAST) begin
                state_next = MAC;
                start      = 1'b1;
            end
            MAC: if (t == T_LAST) begin
                state_next = IDLE;
                load       = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            start      = 1'b0;
            load       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            x_ready <= 1'b1;
        end else begin
            state   <= state_next;
            x_ready <= (state_next == IDLE);
        end
    end

    // Full-precision product and sum; the last product is folded in on the load edge
    assign prod     = PROD_W'(dl[t]) * PROD_W'(coef[t]);
    assign acc_next = acc + ACC_W'(prod);
    assign sum_r    = R_W'(acc_next) + RND;
    assign r        = sum_r >>> OUT_SHIFT;

    if (R_W > OUT_W) begin : g_sat
        logic [R_W-OUT_W:0] top;
        assign top  = r[R_W-1:OUT_W-1];
        assign fits = (&top) || !(|top);
    end else begin : g_nosat
        assign fits = 1'b1;
    end

    assign y_next = fits ? OUT_W'(r) : {r[R_W-1], {(OUT_W-1){~r[R_W-1]}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < int'(NTAPS); k++) dl[k] <= '0;
            p       <= '0;
            t       <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < int'(NTAPS); k++) dl[k] <= '0;
            p       <= '0;
            t       <= '0;
            acc     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            y_valid <= load;
            if (accept) begin
                dl[0] <= x;
                for (int k = 1; k < int'(NTAPS); k++) dl[k] <= dl[k-1];
                p <= (p == P_LAST) ? '0 : p + P_W'(1);
            end
            if (start) begin
                acc <= '0;
                t   <= '0;
            end else if (state == MAC) begin
                acc <= acc_next;
                t   <= t + T_W'(1);
            end
            if (load) begin
                y   <= y_next;
                ovf <= ovf | ~fits;
            end
        end
    end
endmodule

// File: doc/poly_decim_fir.md
# poly_decim_fir

Parametrised decimate-by-D FIR filter with one time-shared multiply-accumulate unit. Coefficients are set by a packed parameter vector. An input valid/ready handshake controls sample acceptance, and the output has rounding, saturation and a sticky overflow flag. It replaces fixed-coefficient, fully parallel decimator stages in the polyphase filter chain wherever the clock-to-sample ratio allows serial computation.

## Interface
- IN_W, 8: input sample width, signed two's complement
- COEF_W, 10: coefficient width, signed
- NTAPS, 21: number of taps (≥2)
- D, 2: decimation factor (1..NTAPS)
- COEFS, {-4,-1,4,9,5,-15,-36,-22,51,161,244,244,161,51,-22,-36,-15,5,9,4,-1}: packed NTAPS*COEF_W bits; tap k occupies bits [k*COEF_W +: COEF_W], tap 0 first in the list
- OUT_W, 20: output width, signed
- OUT_SHIFT, 0: right shift applied to the accumulator before saturation
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous clear of filter state
- x_valid  in  1  input sample present
- x_ready  out  1  block can accept a sample
- x  in  IN_W  input sample
- y_valid  out  1  one-cycle pulse, y updated
- y  out  OUT_W  filtered, decimated output
- ovf  out  1  sticky flag, set when any output saturated

## Operation
- Accumulator width ACC_W = IN_W+COEF_W+ceil(log2(NTAPS)). All products and sums are full precision, so the accumulator never wraps.
- Accept: a sample is taken on any edge where x_valid && x_ready.
- Delay line d[0..NTAPS-1] is initialised to zero. On accept, d shifts (d[k]<=d[k-1]) and d[0]<=x.
- Phase counter p runs 0..D-1. It increments on each accept and wraps at D-1.
- FSM has two states:
  - IDLE: x_ready=1. An accept with p==D-1 moves the FSM to MAC, clears the accumulator and sets the tap counter t=0.
  - MAC: x_ready=0. Each cycle does acc+=COEFS[t]*d[t] and t++. On the cycle with t==NTAPS-1, the FSM returns to IDLE and the output register loads.
- Result: y[n] = Σ c[k]·x[n−k] for n = D−1, 2D−1, …, where x[0] is the first sample after reset or flush.
- Output stage:
  - r = (acc + (OUT_SHIFT>0 ? 2^(OUT_SHIFT−1) : 0)) >>> OUT_SHIFT, i.e. round half toward +∞.
  - If r exceeds the OUT_W signed range, y clamps to 2^(OUT_W−1)−1 or −2^(OUT_W−1) and ovf is set.
- y holds its value between y_valid pulses. The output has no backpressure; downstream must capture y on y_valid.
- Flush (synchronous, highest priority) clears d, p, acc, t, ovf and y, and puts the FSM in IDLE. A flush during MAC aborts the computation and no y_valid is produced. If flush and x_valid occur together, the sample is discarded.
- D==1: every accept starts a MAC pass.

## Timing
- Reset values: x_ready=1, y_valid=0, y=0, ovf=0. FSM=IDLE, p=0, delay line zero.
- Asserting reset mid-MAC aborts immediately with no y_valid.
- The accept edge that starts MAC is E. x_ready is low for exactly NTAPS cycles, following edges E..E+NTAPS−1.
- y and y_valid update on edge E+NTAPS. y_valid is high for that single cycle, and x_ready is already high again in the same cycle.
- Input latency is NTAPS cycles from the final accepted sample to y_valid.
- With x_valid held high, throughput is one output per D+NTAPS cycles (23 at defaults).
- ovf changes only on output-load edges or on flush/reset.

## Test plan
- Impulse (defaults): x=1, then zeros with x_valid continuous.
  - Required: y sequence −1,9,−15,−22,161,244,51,−36,5,4, then 0.
  - Each y_valid arrives 21 cycles after the 2nd sample of its pair is accepted.
- DC: constant x=100. After 21 samples, every y=79600, ovf=0. With x=−128 constant, y=−101888.
- Handshake: x_valid continuous.
  - Required: x_ready low for exactly 21 cycles after every 2nd accept, and a y_valid period of 23 cycles.
  - Also: x_valid toggled randomly produces identical y values to the continuous case.
- Rounding and saturation:
  - OUT_SHIFT=3, constant x=1 → y=100 (99.5 rounded).
  - OUT_W=16, constant x=127 → y=32767, ovf=1 and stays set.
  - A following flush → ovf=0, y=0.
- Abort: reset low, then flush, each asserted mid-MAC.
  - Required: no y_valid, x_ready=1.
  - Next impulse reproduces the first scenario exactly, with phase restarted at 0.
- D=1, NTAPS=4, COEFS={1,2,3,4}: input 1,0,0,0 → y=1,2,3,4, with one y_valid per accept.
